// File: rtl/vp_pkg.sv
// vp_pkg: shared vector register bank widths and the write-back entry type.
package vp_pkg;
  localparam int VREG_W      = 64;
  localparam int VREG_ADDR_W = 3;
  localparam int NUM_VREGS   = 8;
  typedef struct packed {
    logic [VREG_ADDR_W-1:0] dir;
    logic [VREG_W-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/vect_wb_fifo.sv
// vect_wb_fifo: in-order result FIFO with per-entry valid/dir export.
// Ports: clk, rst (async high); push/pop strobes with in_dir/in_data;
// head_dir/head_data at the read pointer; count occupancy;
// valid_vec/dir_vec expose every slot for hazard comparison.
module vect_wb_fifo
  import vp_pkg::*;
#(
  parameter int DATA_W = VREG_W,
  parameter int ADDR_W = VREG_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             in_dir,
  input  logic [DATA_W-1:0]             in_data,
  output logic [ADDR_W-1:0]             head_dir,
  output logic [DATA_W-1:0]             head_data,
  output logic [CW-1:0]                 count,
  output logic [DEPTH-1:0]              valid_vec,
  output logic [DEPTH-1:0][ADDR_W-1:0]  dir_vec
);
  logic [ADDR_W-1:0] dir_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      dir_mem[wr_ptr]  <= in_dir;
      data_mem[wr_ptr] <= in_data;
    end
  assign head_dir  = dir_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = {1'b0, PW'(i) - rd_ptr} < count;
      dir_vec[i]   = dir_mem[i];
    end
endmodule

// File: rtl/vect_writeback_buffer.sv
// vect_writeback_buffer: buffers execute results and drains them to the vector bank.
// Ports: clk, rst (async high); in_valid/in_ready/in_dir/in_data from execute;
// wb_en gates draining; dir_esc/data/signal_esc registered bank write port;
// q_dir_A/q_dir_B operand addresses with hazard_A/hazard_B flags; count, empty.
module vect_writeback_buffer
  import vp_pkg::*;
#(
  parameter int DATA_W = VREG_W,
  parameter int ADDR_W = VREG_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dir,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_en,
  output logic [ADDR_W-1:0] dir_esc,
  output logic [DATA_W-1:0] data,
  output logic              signal_esc,
  input  logic [ADDR_W-1:0] q_dir_A,
  input  logic [ADDR_W-1:0] q_dir_B,
  output logic              hazard_A,
  output logic              hazard_B,
  output logic [CW-1:0]     count,
  output logic              empty
);
  logic                         push, pop;
  logic [ADDR_W-1:0]            head_dir;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             valid_vec;
  logic [DEPTH-1:0][ADDR_W-1:0] dir_vec;
  assign in_ready = !rst && count < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = wb_en && count != '0;
  assign empty    = count == '0;
  vect_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .in_dir    (in_dir),
    .in_data   (in_data),
    .head_dir  (head_dir),
    .head_data (head_data),
    .count     (count),
    .valid_vec (valid_vec),
    .dir_vec   (dir_vec)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir_esc    <= '0;
      data       <= '0;
      signal_esc <= 1'b0;
    end else begin
      signal_esc <= pop;
      if (pop) begin
        dir_esc <= head_dir;
        data    <= head_data;
      end
    end
  // The entry in the output register is already out of the FIFO; the bank
  // commits it on the negedge, ahead of the next operand read.
  always_comb begin
    hazard_A = 1'b0;
    hazard_B = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_A = hazard_A | (valid_vec[i] && dir_vec[i] == q_dir_A);
      hazard_B = hazard_B | (valid_vec[i] && dir_vec[i] == q_dir_B);
    end
  end
endmodule

// File: tb/tb_vect_writeback_buffer.sv
// tb_vect_writeback_buffer: directed self-checking bench for vect_writeback_buffer.
module tb_vect_writeback_buffer;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  in_dir = 0;
  logic [63:0] in_data = 0;
  logic        wb_en = 0;
  logic [2:0]  dir_esc;
  logic [63:0] data;
  logic        signal_esc;
  logic [2:0]  q_dir_A = 0;
  logic [2:0]  q_dir_B = 0;
  logic        hazard_A, hazard_B;
  logic [2:0]  count;
  logic        empty;
  logic [63:0] bank [8];
  int          errors = 0;
  int          checks = 0;
  vect_writeback_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_data(in_data), .wb_en(wb_en),
    .dir_esc(dir_esc), .data(data), .signal_esc(signal_esc),
    .q_dir_A(q_dir_A), .q_dir_B(q_dir_B), .hazard_A(hazard_A), .hazard_B(hazard_B),
    .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (signal_esc) bank[dir_esc] = data;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) bank[i] = '0;
    in_valid = 1; in_dir = 7; in_data = 64'h77;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_strobe", signal_esc, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_hazA", hazard_A, 1'b0);
    rst = 0; in_valid = 0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_empty", empty, 1'b1);
    q_dir_A = 3; in_valid = 1; in_dir = 3; in_data = 64'hDEAD_BEEF_0000_0001; wb_en = 1;
    tick();
    in_valid = 0;
    chk("sw_hazA_N", hazard_A, 1'b1);
    chk("sw_count_N", count, 3'd1);
    chk("sw_strobe_N", signal_esc, 1'b0);
    tick();
    chk("sw_strobe_N1", signal_esc, 1'b1);
    chk("sw_dir", dir_esc, 3'd3);
    chk("sw_data", data, 64'hDEAD_BEEF_0000_0001);
    chk("sw_hazA_N1", hazard_A, 1'b0);
    chk("sw_empty", empty, 1'b1);
    tick();
    chk("sw_strobe_N2", signal_esc, 1'b0);
    chk("sw_bank3", bank[3], 64'hDEAD_BEEF_0000_0001);
    wb_en = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_dir = 3'(i); in_data = 64'(10 + i);
      tick();
    end
    in_dir = 4; in_data = 64'd14;
    #1;
    chk("full_count", count, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    tick();
    chk("full_held", count, 3'd4);
    chk("full_nostrobe", signal_esc, 1'b0);
    wb_en = 1;
    tick();
    chk("drain0_strobe", signal_esc, 1'b1);
    chk("drain0_dir", dir_esc, 3'd0);
    chk("drain0_count", count, 3'd3);
    chk("drain0_ready", in_ready, 1'b1);
    tick();
    in_valid = 0;
    chk("drain1_dir", dir_esc, 3'd1);
    chk("drain1_data", data, 64'd11);
    chk("drain1_count", count, 3'd3);
    tick();
    chk("drain2_dir", dir_esc, 3'd2);
    chk("drain2_strobe", signal_esc, 1'b1);
    tick();
    chk("drain3_dir", dir_esc, 3'd3);
    chk("drain3_data", data, 64'd13);
    tick();
    chk("drain4_dir", dir_esc, 3'd4);
    chk("drain4_data", data, 64'd14);
    chk("drain4_count", count, 3'd0);
    tick();
    chk("drain_idle", signal_esc, 1'b0);
    chk("drain_dir_hold", dir_esc, 3'd4);
    chk("drain_bank2", bank[2], 64'd12);
    wb_en = 0; in_valid = 1;
    in_dir = 6; in_data = 64'd20; tick();
    in_dir = 7; in_data = 64'd21; tick();
    chk("sim_pre_count", count, 3'd2);
    wb_en = 1; in_dir = 1; in_data = 64'd22;
    tick();
    in_valid = 0;
    chk("sim_count", count, 3'd2);
    chk("sim_dir", dir_esc, 3'd6);
    chk("sim_data", data, 64'd20);
    tick();
    chk("sim_dir2", dir_esc, 3'd7);
    tick();
    chk("sim_dir3", dir_esc, 3'd1);
    chk("sim_data3", data, 64'd22);
    chk("sim_empty", empty, 1'b1);
    tick();
    q_dir_B = 5; wb_en = 0; in_valid = 1;
    in_dir = 5; in_data = 64'd1; tick();
    in_dir = 5; in_data = 64'd2; tick();
    in_valid = 0;
    chk("same_hazB", hazard_B, 1'b1);
    chk("same_hazA", hazard_A, 1'b0);
    chk("same_count", count, 3'd2);
    wb_en = 1;
    tick();
    chk("same_data1", data, 64'd1);
    chk("same_hazB_mid", hazard_B, 1'b1);
    tick();
    chk("same_data2", data, 64'd2);
    chk("same_dir2", dir_esc, 3'd5);
    chk("same_hazB_done", hazard_B, 1'b0);
    tick();
    chk("same_bank5", bank[5], 64'd2);
    wb_en = 0; in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      in_dir = 3'(i); in_data = 64'(30 + i);
      tick();
    end
    in_valid = 0; wb_en = 1;
    tick();
    chk("rmd_strobe", signal_esc, 1'b1);
    chk("rmd_count", count, 3'd2);
    #2 rst = 1;
    #1;
    chk("rmd_strobe_drop", signal_esc, 1'b0);
    chk("rmd_count_zero", count, 3'd0);
    chk("rmd_ready", in_ready, 1'b0);
    chk("rmd_dir", dir_esc, 3'd0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmd_no_strobe", signal_esc, 1'b0);
      chk("rmd_post_count", count, 3'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vect_writeback_buffer.md
Name: vect_writeback_buffer

Overview:
Write-side producer for the 8 x 64-bit vector register bank. It accepts results from the vector execute stage over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the bank write port (`dir_esc`/`data`/`signal_esc`). It also reports read-after-write hazards so operand fetch can hold `signal_read` until pending writes have landed.

Parameters:
- DATA_W, 64, vector register width in bits
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk, in, 1, clock; all state updates on posedge
- rst, in, 1, reset, asynchronous, active-high
- in_valid, in, 1, execute stage presents a result
- in_ready, out, 1, buffer can accept; combinational, equals count < DEPTH and !rst
- in_dir, in, ADDR_W, destination register
- in_data, in, DATA_W, result value
- wb_en, in, 1, permission to drive the bank write port this cycle
- dir_esc, out, ADDR_W, registered write address to bank
- data, out, DATA_W, registered write data to bank
- signal_esc, out, 1, registered write strobe to bank
- q_dir_A, in, ADDR_W, operand A address being fetched
- q_dir_B, in, ADDR_W, operand B address being fetched
- hazard_A, out, 1, combinational: a buffered entry targets q_dir_A
- hazard_B, out, 1, combinational: a buffered entry targets q_dir_B
- count, out, $clog2(DEPTH)+1, current occupancy
- empty, out, 1, count == 0

Behaviour:
- Reset (async assert, sync release), all outputs go to these values: count 0, empty 1, signal_esc 0, dir_esc 0, data 0, hazard_A/B 0. in_ready is 0 while rst is high.
- Push: in_valid && in_ready at a posedge writes {in_dir, in_data} at the tail.
- Pop: at a posedge with count > 0 and wb_en = 1:
  - the head loads into dir_esc/data;
  - signal_esc is registered to 1 for that cycle;
  - otherwise signal_esc is registered to 0, and dir_esc/data hold their values.
- Latency: an entry pushed into an empty buffer at edge N appears on the write port after edge N+1 (strobe high for cycle N+1..N+2). The bank commits it on the following negedge.
- Simultaneous push and pop in the same edge: count is unchanged. This is legal at any count < DEPTH.
- Full: in_ready = 0. There is no pass-through when full, even if a pop occurs that edge.
- Empty with wb_en = 1: no strobe; wb_en has no effect.
- Ordering: strictly in order. Same-address entries are never merged or reordered, so the last write wins in the bank.
- Hazards:
  - hazard_X = OR over valid FIFO entries of (entry.dir == q_dir_X).
  - The entry held in the output register is excluded, because the bank writes it on the negedge before the next posedge read.
  - An entry being pushed this cycle is not included until it is registered.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by count, not by pointer compare.
- Reset mid-operation: all buffered entries are discarded and no further strobes are issued.

Decomposition:
- Package vp_pkg holds:
  - VREG_W = 64, VREG_ADDR_W = 3, NUM_VREGS = 8;
  - typedef struct packed wb_entry_t { logic [VREG_ADDR_W-1:0] dir; logic [VREG_W-1:0] data; }.
- Sub-module vect_wb_fifo: storage, pointers, count, and a per-entry valid/dir vector exported for the hazard compare.
- The top level contains the output register and the hazard logic.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid = 1 -> in_ready 0, signal_esc 0, count 0. After release, in_ready 1 and empty 1.
- Single write:
  - stimulus: push dir 3, data 64'hDEAD_BEEF_0000_0001 at edge N with wb_en = 1, and q_dir_A = 3;
  - response: hazard_A 1 after edge N; after edge N+1, signal_esc 1 for exactly one cycle with dir_esc 3 and that data; hazard_A 0 after edge N+1.
- Fill/backpressure:
  - stimulus: wb_en = 0, push dirs 0,1,2,3 (data 10..13), then attempt dir 4;
  - response: count 4, in_ready 0, dir 4 held. Raising wb_en gives 4 consecutive strobes in order 0,1,2,3. Dir 4 is accepted the edge after in_ready rises.
- Simultaneous push/pop at count 2: count stays 2 and the strobe carries the old head.
- Same-address ordering:
  - stimulus: push dir 5 data 1, then dir 5 data 2;
  - response: two strobes in order, bank reg 5 reads 2; hazard_B (q_dir_B = 5) stays 1 until the second entry pops.
- Reset mid-drain: with 3 entries and wb_en = 1, assert rst asynchronously mid-cycle -> signal_esc drops immediately, count 0, and no strobes follow the release.
